// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: shares one registered memory bus between the
// instruction-fetch port and the load/store port, with anti-starvation for fetch.
module mem_port_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        IfReq,
  input  logic [63:0] IfAddr,
  input  logic        IfKill,
  output logic [31:0] IfRdata,
  output logic        IfReady,
  input  logic        MemReq,
  input  logic        MemWe,
  input  logic [63:0] MemAddr,
  input  logic [63:0] MemWdata,
  input  logic [7:0]  MemWmask,
  output logic [63:0] MemRdata,
  output logic        MemReady,
  output logic        BusReq,
  output logic        BusWe,
  output logic [63:0] BusAddr,
  output logic [63:0] BusWdata,
  output logic [7:0]  BusWmask,
  input  logic        BusAck,
  input  logic [63:0] BusRdata,
  output logic        HoldOut,
  output logic [1:0]  DbgState
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUS  = 2'd1,
    MEM_BUS = 2'd2,
    RESP    = 2'd3
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state;
  state_t      state_nxt;
  logic        owner_if;
  logic        killed;
  logic [3:0]  starve_cnt;
  logic [63:0] rdata_reg;

  logic if_live;
  logic starved;
  logic grant_mem;
  logic grant_if;
  logic on_bus;

  // A fetch raised together with a kill is not a live request, so it can
  // neither win arbitration nor force the starvation override that cycle.
  always_comb begin
    if_live   = IfReq & ~IfKill;
    starved   = if_live & (starve_cnt == STARVE_LIM);
    grant_mem = (state == IDLE) & MemReq & ~starved;
    grant_if  = (state == IDLE) & if_live & ~grant_mem;
    on_bus    = (state == IF_BUS) | (state == MEM_BUS);

    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_mem)     state_nxt = MEM_BUS;
        else if (grant_if) state_nxt = IF_BUS;
      end
      IF_BUS, MEM_BUS: begin
        if (BusAck) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      BusReq     <= 1'b0;
      BusWe      <= 1'b0;
      BusAddr    <= '0;
      BusWdata   <= '0;
      BusWmask   <= '0;
      owner_if   <= 1'b0;
      killed     <= 1'b0;
      starve_cnt <= '0;
      rdata_reg  <= '0;
    end else begin
      if (grant_mem) begin
        BusReq   <= 1'b1;
        BusWe    <= MemWe;
        BusAddr  <= MemAddr;
        BusWdata <= MemWdata;
        BusWmask <= MemWmask;
        owner_if <= 1'b0;
      end else if (grant_if) begin
        BusReq   <= 1'b1;
        BusWe    <= 1'b0;
        BusAddr  <= IfAddr;
        BusWdata <= '0;
        BusWmask <= '0;
        owner_if <= 1'b1;
      end

      if (on_bus && BusAck) begin
        BusReq    <= 1'b0;
        rdata_reg <= BusRdata;
      end

      // The kill only silences the response; the bus cycle itself runs to completion.
      if (state == RESP)                   killed <= 1'b0;
      else if (state == IF_BUS && IfKill)  killed <= 1'b1;

      if (!IfReq || grant_if)                         starve_cnt <= '0;
      else if (grant_mem && starve_cnt < STARVE_LIM)  starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // BusAddr still holds the fetch address latched at grant, so bit 2 picks the word.
  assign IfRdata  = BusAddr[2] ? rdata_reg[63:32] : rdata_reg[31:0];
  assign MemRdata = rdata_reg;
  assign IfReady  = (state == RESP) & owner_if & ~killed & ~IfKill;
  assign MemReady = (state == RESP) & ~owner_if;
  assign HoldOut  = (IfReq & ~IfReady) | (MemReq & ~MemReady);
  assign DbgState = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 3;

  logic        Clk, Rst;
  logic        IfReq, IfKill, IfReady;
  logic [63:0] IfAddr;
  logic [31:0] IfRdata;
  logic        MemReq, MemWe, MemReady;
  logic [63:0] MemAddr, MemWdata, MemRdata;
  logic [7:0]  MemWmask;
  logic        BusReq, BusWe, BusAck;
  logic [63:0] BusAddr, BusWdata, BusRdata;
  logic [7:0]  BusWmask;
  logic        HoldOut;
  logic [1:0]  DbgState;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .Clk(Clk), .Rst(Rst),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfKill(IfKill), .IfRdata(IfRdata), .IfReady(IfReady),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWdata(MemWdata),
    .MemWmask(MemWmask), .MemRdata(MemRdata), .MemReady(MemReady),
    .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusWdata(BusWdata),
    .BusWmask(BusWmask), .BusAck(BusAck), .BusRdata(BusRdata),
    .HoldOut(HoldOut), .DbgState(DbgState)
  );

  // clock / reset
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    IfReq = 0; IfKill = 0; IfAddr = '0;
    MemReq = 0; MemWe = 0; MemAddr = '0; MemWdata = '0; MemWmask = '0;
    BusAck = 0; BusRdata = '0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
  endtask

  // vector table
  typedef struct {
    logic        if_req;
    logic        if_kill;
    logic [63:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic        bus_ack;
    logic        e_bus_req;
    logic        e_bus_we;
    logic [63:0] e_bus_addr;
    logic        e_if_ready;
    logic        e_mem_ready;
    logic [63:0] e_rdata;
    logic        e_hold;
  } vec_t;

  localparam logic [63:0] FA  = 64'h0000_0000_8000_0004;
  localparam logic [63:0] FB  = 64'h0000_0000_8000_0010;
  localparam logic [63:0] MA  = 64'h0000_0000_8000_1000;
  localparam logic [63:0] RD  = 64'h1122_3344_5566_7788;

  vec_t vecs[18];

  // reference model state
  typedef struct {
    logic        is_if;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
  } txn_t;

  txn_t        cur;
  bit          m_bus, m_resp, m_kill;
  int          m_streak;
  logic [63:0] exp_q[$];

  function automatic logic [63:0] rnd_addr();
    return {32'h0000_0000, 4'h8, 28'($urandom) & 28'hFFF_FFFC};
  endfunction

  task automatic model_cycle();
    logic        e_if_rdy, e_mem_rdy, if_ok;
    logic [63:0] d;
    e_if_rdy  = m_resp && cur.is_if && !m_kill && !IfKill;
    e_mem_rdy = m_resp && !cur.is_if;
    chk("rnd_bus_req", BusReq, m_bus);
    if (m_bus) begin
      chk("rnd_bus_addr", BusAddr, cur.addr);
      chk("rnd_bus_we", BusWe, cur.we);
      chk("rnd_bus_wmask", BusWmask, cur.mask);
      if (!cur.is_if) chk("rnd_bus_wdata", BusWdata, cur.wdata);
    end
    chk("rnd_if_ready", IfReady, e_if_rdy);
    chk("rnd_mem_ready", MemReady, e_mem_rdy);
    chk("rnd_hold", HoldOut, (IfReq && !e_if_rdy) || (MemReq && !e_mem_rdy));
    if (m_resp) begin
      d = exp_q.pop_front();
      if (e_if_rdy)  chk("rnd_if_rdata", IfRdata, cur.addr[2] ? d[63:32] : d[31:0]);
      if (e_mem_rdy) chk("rnd_mem_rdata", MemRdata, d);
    end
    // advance the model across the coming clock edge
    if (m_resp) begin
      m_resp = 0;
      m_kill = 0;
    end else if (m_bus) begin
      if (cur.is_if && IfKill) m_kill = 1;
      if (BusAck) begin
        exp_q.push_back(BusRdata);
        m_bus  = 0;
        m_resp = 1;
      end
    end else begin
      if_ok = IfReq && !IfKill;
      if (MemReq && !(if_ok && m_streak == STARVE_MAX)) begin
        cur = '{1'b0, MemWe, MemAddr, MemWdata, MemWmask};
        m_bus = 1;
        if (IfReq) m_streak = (m_streak + 1 > STARVE_MAX) ? STARVE_MAX : m_streak + 1;
      end else if (if_ok) begin
        cur = '{1'b1, 1'b0, IfAddr, 64'h0, 8'h0};
        m_bus = 1;
        m_streak = 0;
      end
    end
    if (!IfReq) m_streak = 0;
  endtask

  initial begin
    logic        got_order[5];
    logic        exp_order[5];
    logic        prev_req, last_rdy, last_if_rdy, last_mem_rdy;
    int          n_grant, pulses;
    logic [63:0] slow_addr, slow_data;

    //      ifq kil addr mq we ack | breq bwe baddr ifr memr rdata     hold
    vecs[0]  = '{1, 0, FA, 0, 0, 0,  0, 0, 64'h0, 0, 0, 64'h0, 1};
    vecs[1]  = '{1, 0, FA, 0, 0, 0,  1, 0, FA,    0, 0, 64'h0, 1};
    vecs[2]  = '{1, 0, FA, 0, 0, 0,  1, 0, FA,    0, 0, 64'h0, 1};
    vecs[3]  = '{1, 0, FA, 0, 0, 1,  1, 0, FA,    0, 0, 64'h0, 1};
    vecs[4]  = '{1, 0, FA, 0, 0, 0,  0, 0, 64'h0, 1, 0, 64'h11223344, 0};
    vecs[5]  = '{0, 0, FA, 0, 0, 0,  0, 0, 64'h0, 0, 0, 64'h0, 0};
    vecs[6]  = '{0, 0, FA, 1, 1, 0,  0, 0, 64'h0, 0, 0, 64'h0, 1};
    vecs[7]  = '{0, 0, FA, 1, 1, 1,  1, 1, MA,    0, 0, 64'h0, 1};
    vecs[8]  = '{0, 0, FA, 1, 1, 0,  0, 0, 64'h0, 0, 1, 64'h0, 0};
    vecs[9]  = '{0, 0, FB, 0, 0, 0,  0, 0, 64'h0, 0, 0, 64'h0, 0};
    vecs[10] = '{1, 0, FB, 0, 0, 0,  0, 0, 64'h0, 0, 0, 64'h0, 1};
    vecs[11] = '{1, 1, FB, 0, 0, 0,  1, 0, FB,    0, 0, 64'h0, 1};
    vecs[12] = '{1, 0, FB, 0, 0, 1,  1, 0, FB,    0, 0, 64'h0, 1};
    vecs[13] = '{1, 0, FB, 0, 0, 0,  0, 0, 64'h0, 0, 0, 64'h0, 1};
    vecs[14] = '{1, 0, FB, 0, 0, 0,  0, 0, 64'h0, 0, 0, 64'h0, 1};
    vecs[15] = '{1, 0, FB, 0, 0, 1,  1, 0, FB,    0, 0, 64'h0, 1};
    vecs[16] = '{1, 0, FB, 0, 0, 0,  0, 0, 64'h0, 1, 0, 64'h55667788, 0};
    vecs[17] = '{0, 0, FB, 0, 0, 0,  0, 0, 64'h0, 0, 0, 64'h0, 0};

    // reset state
    do_reset();
    #1;
    chk("rst_bus_req", BusReq, 0);
    chk("rst_bus_we", BusWe, 0);
    chk("rst_bus_addr", BusAddr, 0);
    chk("rst_bus_wdata", BusWdata, 0);
    chk("rst_bus_wmask", BusWmask, 0);
    chk("rst_if_ready", IfReady, 0);
    chk("rst_mem_ready", MemReady, 0);
    chk("rst_hold", HoldOut, 0);
    chk("rst_state", DbgState, 0);

    // fetch, store, killed fetch then refetch
    MemAddr = MA; MemWdata = 64'hDEADBEEF; MemWmask = 8'h0F; BusRdata = RD;
    for (int i = 0; i < 18; i++) begin
      @(negedge Clk);
      IfReq = vecs[i].if_req; IfKill = vecs[i].if_kill; IfAddr = vecs[i].if_addr;
      MemReq = vecs[i].mem_req; MemWe = vecs[i].mem_we; BusAck = vecs[i].bus_ack;
      #1;
      chk($sformatf("vec%0d_bus_req", i), BusReq, vecs[i].e_bus_req);
      chk($sformatf("vec%0d_if_ready", i), IfReady, vecs[i].e_if_ready);
      chk($sformatf("vec%0d_mem_ready", i), MemReady, vecs[i].e_mem_ready);
      chk($sformatf("vec%0d_hold", i), HoldOut, vecs[i].e_hold);
      if (vecs[i].e_bus_req) begin
        chk($sformatf("vec%0d_bus_addr", i), BusAddr, vecs[i].e_bus_addr);
        chk($sformatf("vec%0d_bus_we", i), BusWe, vecs[i].e_bus_we);
        if (vecs[i].e_bus_we) begin
          chk($sformatf("vec%0d_bus_wdata", i), BusWdata, 64'hDEADBEEF);
          chk($sformatf("vec%0d_bus_wmask", i), BusWmask, 8'h0F);
        end else begin
          chk($sformatf("vec%0d_bus_wmask", i), BusWmask, 8'h00);
        end
      end
      if (vecs[i].e_if_ready) chk($sformatf("vec%0d_if_rdata", i), IfRdata, vecs[i].e_rdata);
    end

    // contention with starvation override
    do_reset();
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    IfAddr = 64'h8000_0100; MemAddr = 64'h8000_2000; MemWe = 0;
    IfReq = 1; MemReq = 1;
    n_grant = 0; prev_req = 0;
    for (int c = 0; c < 60 && n_grant < 5; c++) begin
      @(negedge Clk);
      BusAck = BusReq;
      #1;
      if (IfReady && MemReady) chk("contend_dual_ready", 1, 0);
      if (BusReq && !prev_req) begin
        got_order[n_grant] = (BusAddr == IfAddr);
        n_grant++;
      end
      prev_req = BusReq;
    end
    chk("contend_grants", n_grant, 5);
    for (int k = 0; k < n_grant; k++)
      chk($sformatf("contend_order%0d", k), got_order[k], exp_order[k]);

    // reset during MEM_BUS
    do_reset();
    @(negedge Clk); MemReq = 1; MemWe = 0; MemAddr = 64'h8000_3000; #1;
    @(negedge Clk); #1;
    chk("rstmid_bus_req_before", BusReq, 1);
    @(negedge Clk); Rst = 1; #1;
    @(negedge Clk); Rst = 0; MemReq = 0; BusAck = 1; BusRdata = 64'hABCD; #1;
    chk("rstmid_bus_req", BusReq, 0);
    chk("rstmid_bus_addr", BusAddr, 0);
    chk("rstmid_bus_we", BusWe, 0);
    chk("rstmid_bus_wdata", BusWdata, 0);
    chk("rstmid_bus_wmask", BusWmask, 0);
    chk("rstmid_mem_ready", MemReady, 0);
    chk("rstmid_if_ready", IfReady, 0);
    chk("rstmid_state", DbgState, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk); BusAck = 0; #1;
      chk("rstmid_no_ready", MemReady, 0);
      chk("rstmid_no_req", BusReq, 0);
    end

    // slow bus: ack 10 cycles late on a load
    do_reset();
    slow_addr = 64'h8000_4008; slow_data = 64'hCAFEF00D_12345678;
    @(negedge Clk); MemReq = 1; MemWe = 0; MemAddr = slow_addr; #1;
    chk("slow_hold_req", HoldOut, 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk); BusAck = 0; BusRdata = {$urandom, $urandom}; #1;
      chk("slow_bus_req", BusReq, 1);
      chk("slow_bus_addr", BusAddr, slow_addr);
      chk("slow_bus_we", BusWe, 0);
      chk("slow_hold", HoldOut, 1);
      chk("slow_early_ready", MemReady, 0);
    end
    @(negedge Clk); BusAck = 1; BusRdata = slow_data; #1;
    chk("slow_ack_bus_req", BusReq, 1);
    pulses = 0; last_rdy = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk); BusAck = 0; BusRdata = ~slow_data;
      if (last_rdy) MemReq = 0;
      #1;
      if (MemReady) begin
        pulses++;
        chk("slow_mem_rdata", MemRdata, slow_data);
      end
      last_rdy = MemReady;
    end
    chk("slow_ready_pulses", pulses, 1);

    // randomized traffic against the reference model
    do_reset();
    m_bus = 0; m_resp = 0; m_kill = 0; m_streak = 0; exp_q.delete();
    last_if_rdy = 0; last_mem_rdy = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      if (last_if_rdy || !IfReq) begin
        IfReq  = ($urandom_range(0, 2) != 0);
        IfAddr = rnd_addr();
      end
      IfKill = ($urandom_range(0, 19) == 0);
      if (IfKill) IfAddr = rnd_addr();
      if (last_mem_rdy || !MemReq) begin
        MemReq   = ($urandom_range(0, 1) != 0);
        MemWe    = 1'($urandom_range(0, 1));
        MemAddr  = {$urandom, $urandom};
        MemWdata = {$urandom, $urandom};
        MemWmask = 8'($urandom);
      end
      BusAck   = BusReq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      BusRdata = {$urandom, $urandom};
      #1;
      model_cycle();
      last_if_rdy  = IfReady;
      last_mem_rdy = MemReady;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
